// File: rtl/sd_arb_pkg.sv
// Shared constants and state encoding for the SD sector-read arbiter.
package sd_arb_pkg;

   localparam int unsigned SEC_ADDR_W = 32;
   localparam int unsigned SEC_NUM_W  = 16;
   localparam int unsigned DATA_W     = 16;

   // 100 ms at 50 MHz
   localparam logic [25:0] DEF_START_TIMEOUT = 26'd5_000_000;

   typedef logic [2:0] state_t;

   localparam state_t StIdle     = 3'd0;
   localparam state_t StStart    = 3'd1;
   localparam state_t StWaitBusy = 3'd2;
   localparam state_t StWaitDone = 3'd3;
   localparam state_t StFinish   = 3'd4;

endpackage

// File: rtl/sd_busy_edge.sv
// Two-flop delay of the SD controller busy flag with rise/fall strobes.
module sd_busy_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic busy,
   output logic rise,
   output logic fall
);

   logic d0_q, d1_q;

   // Delay line; edges are judged between the two stages.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d0_q <= 1'b0;
         d1_q <= 1'b0;
      end else begin
         d0_q <= busy;
         d1_q <= d0_q;
      end
   end

   assign rise = d0_q & ~d1_q;
   assign fall = d1_q & ~d0_q;

endmodule

// File: rtl/sd_read_arbiter.sv
// Round-robin arbiter sharing one SD sector-read engine between two burst requesters.
module sd_read_arbiter
   import sd_arb_pkg::*;
#(
   parameter logic [25:0] START_TIMEOUT = DEF_START_TIMEOUT,
   parameter int unsigned MAX_RETRY     = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req0,
   input  logic [SEC_ADDR_W-1:0] req0_addr,
   input  logic [SEC_NUM_W-1:0]  req0_num,
   input  logic                  req1,
   input  logic [SEC_ADDR_W-1:0] req1_addr,
   input  logic [SEC_NUM_W-1:0]  req1_num,
   output logic                  gnt0,
   output logic                  gnt1,
   output logic                  done0,
   output logic                  done1,
   output logic                  err0,
   output logic                  err1,
   output logic                  val_en0,
   output logic                  val_en1,
   output logic [DATA_W-1:0]     val_data0,
   output logic [DATA_W-1:0]     val_data1,
   input  logic                  rd_busy,
   input  logic                  sd_rd_val_en,
   input  logic [DATA_W-1:0]     sd_rd_val_data,
   output logic                  rd_start_en,
   output logic [SEC_ADDR_W-1:0] rd_sec_addr
);

   localparam logic [7:0] RETRY_LAST = 8'(MAX_RETRY - 1);

   state_t                state_q, state_d;
   logic                  last_q, last_d;
   logic                  port_q, port_d;
   logic [SEC_ADDR_W-1:0] cur_addr_q, cur_addr_d;
   logic [SEC_NUM_W-1:0]  remain_q, remain_d;
   logic [7:0]            retry_q, retry_d;
   logic [25:0]           tmr_q, tmr_d;
   logic                  tmo_q, tmo_d;
   logic                  abort_q, abort_d;
   logic                  start_q, start_d;
   logic [SEC_ADDR_W-1:0] sec_addr_q, sec_addr_d;
   logic                  gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic                  done0_q, done0_d, done1_q, done1_d;
   logic                  err0_q, err0_d, err1_q, err1_d;
   logic                  busy_rise, busy_fall;
   logic                  pick;

   sd_busy_edge u_busy_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .busy  (rd_busy),
      .rise  (busy_rise),
      .fall  (busy_fall)
   );

   // Port 1 wins only when it is alone or port 0 was served last.
   assign pick = req1 & (~req0 | ~last_q);

   // Next-state and registered-output logic of the burst sequencer.
   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      port_d     = port_q;
      cur_addr_d = cur_addr_q;
      remain_d   = remain_q;
      retry_d    = retry_q;
      tmr_d      = tmr_q;
      abort_d    = abort_q;
      sec_addr_d = sec_addr_q;
      gnt0_d     = gnt0_q;
      gnt1_d     = gnt1_q;
      start_d    = 1'b0;
      // Expiry is registered, so a timeout acts one cycle after the count hits its limit.
      tmo_d      = (state_q == StWaitBusy) && (tmr_q == START_TIMEOUT - 26'd1);
      case (state_q)
         StIdle: begin
            if (req0 || req1) begin
               port_d     = pick;
               cur_addr_d = pick ? req1_addr : req0_addr;
               remain_d   = pick ? req1_num : req0_num;
               gnt0_d     = ~pick;
               gnt1_d     = pick;
               retry_d    = 8'd0;
               abort_d    = 1'b0;
               state_d    = (remain_d == '0) ? StFinish : StStart;
            end
         end
         StStart: begin
            start_d    = 1'b1;
            sec_addr_d = cur_addr_q;
            tmr_d      = 26'd0;
            state_d    = StWaitBusy;
         end
         StWaitBusy: begin
            if (busy_rise) begin
               state_d = StWaitDone;
            end else if (tmo_q) begin
               if (retry_q == RETRY_LAST) begin
                  abort_d = 1'b1;
                  state_d = StFinish;
               end else begin
                  retry_d = retry_q + 8'd1;
                  state_d = StStart;
               end
            end else begin
               tmr_d = tmr_q + 26'd1;
            end
         end
         StWaitDone: begin
            if (busy_fall) begin
               cur_addr_d = cur_addr_q + 32'd1;
               remain_d   = remain_q - 16'd1;
               state_d    = (remain_q == 16'd1) ? StFinish : StStart;
            end
         end
         StFinish: begin
            gnt0_d  = 1'b0;
            gnt1_d  = 1'b0;
            last_d  = port_q;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      // FINISH lasts exactly one cycle, so done/err pulse on entry only.
      done0_d = (state_d == StFinish) & ~port_d;
      done1_d = (state_d == StFinish) & port_d;
      err0_d  = done0_d & abort_d;
      err1_d  = done1_d & abort_d;
   end

   // State register; everything clears on reset except last, which favours port 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         last_q     <= 1'b1;
         port_q     <= 1'b0;
         cur_addr_q <= '0;
         remain_q   <= '0;
         retry_q    <= '0;
         tmr_q      <= '0;
         tmo_q      <= 1'b0;
         abort_q    <= 1'b0;
         start_q    <= 1'b0;
         sec_addr_q <= '0;
         gnt0_q     <= 1'b0;
         gnt1_q     <= 1'b0;
         done0_q    <= 1'b0;
         done1_q    <= 1'b0;
         err0_q     <= 1'b0;
         err1_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         port_q     <= port_d;
         cur_addr_q <= cur_addr_d;
         remain_q   <= remain_d;
         retry_q    <= retry_d;
         tmr_q      <= tmr_d;
         tmo_q      <= tmo_d;
         abort_q    <= abort_d;
         start_q    <= start_d;
         sec_addr_q <= sec_addr_d;
         gnt0_q     <= gnt0_d;
         gnt1_q     <= gnt1_d;
         done0_q    <= done0_d;
         done1_q    <= done1_d;
         err0_q     <= err0_d;
         err1_q     <= err1_d;
      end
   end

   assign gnt0        = gnt0_q;
   assign gnt1        = gnt1_q;
   assign done0       = done0_q;
   assign done1       = done1_q;
   assign err0        = err0_q;
   assign err1        = err1_q;
   assign rd_start_en = start_q;
   assign rd_sec_addr = sec_addr_q;

   // Read data goes only to the granted port; stray beats while idle are dropped.
   assign val_en0   = sd_rd_val_en & gnt0_q;
   assign val_en1   = sd_rd_val_en & gnt1_q;
   assign val_data0 = gnt0_q ? sd_rd_val_data : '0;
   assign val_data1 = gnt1_q ? sd_rd_val_data : '0;

endmodule

// File: tb/tb_sd_read_arbiter.sv
// Randomised bench for sd_read_arbiter with an SD controller model and a burst-level reference.
module tb_sd_read_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0, req1;
   logic [31:0] req0_addr, req1_addr;
   logic [15:0] req0_num, req1_num;
   logic        gnt0, gnt1, done0, done1, err0, err1, val_en0, val_en1;
   logic [15:0] val_data0, val_data1;
   logic        rd_busy, sd_rd_val_en;
   logic [15:0] sd_rd_val_data;
   logic        rd_start_en;
   logic [31:0] rd_sec_addr;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   // Reference state
   bit          last_m = 1'b1;
   int          exp_owner = -1;
   bit          sd_respond = 1'b1;
   bit          sd_stray = 1'b0;
   int          busy_len = 6;
   logic [31:0] st_addr_q[$];
   int          st_cyc_q[$];

   sd_read_arbiter #(
      .START_TIMEOUT (26'd20),
      .MAX_RETRY     (3)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req0           (req0),
      .req0_addr      (req0_addr),
      .req0_num       (req0_num),
      .req1           (req1),
      .req1_addr      (req1_addr),
      .req1_num       (req1_num),
      .gnt0           (gnt0),
      .gnt1           (gnt1),
      .done0          (done0),
      .done1          (done1),
      .err0           (err0),
      .err1           (err1),
      .val_en0        (val_en0),
      .val_en1        (val_en1),
      .val_data0      (val_data0),
      .val_data1      (val_data1),
      .rd_busy        (rd_busy),
      .sd_rd_val_en   (sd_rd_val_en),
      .sd_rd_val_data (sd_rd_val_data),
      .rd_start_en    (rd_start_en),
      .rd_sec_addr    (rd_sec_addr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // SD controller: busy rises 2 cycles after a start, data beats while busy.
   initial begin
      rd_busy        = 1'b0;
      sd_rd_val_en   = 1'b0;
      sd_rd_val_data = 16'h0;
      forever begin
         @(posedge clk);
         #1;
         if (rd_start_en && sd_respond && rst_n) begin
            sd_rd_val_en = 1'b0;
            repeat (2) begin @(posedge clk); #1; end
            rd_busy = 1'b1;
            for (int i = 0; i < busy_len && rst_n; i++) begin
               @(posedge clk);
               #1;
               sd_rd_val_en   = i[0];
               sd_rd_val_data = 16'($urandom);
            end
            sd_rd_val_en = 1'b0;
            rd_busy      = 1'b0;
         end else begin
            sd_rd_val_en   = sd_stray & rst_n;
            sd_rd_val_data = sd_stray ? 16'hBEEF : 16'h0;
         end
         if (!rst_n) rd_busy = 1'b0;
      end
   end

   // Start-pulse recorder.
   initial forever begin
      @(negedge clk);
      if (rd_start_en) begin
         st_addr_q.push_back(rd_sec_addr);
         st_cyc_q.push_back(cyc);
      end
   end

   // Steering checker: every valid beat must reach exactly the owning port.
   initial forever begin
      @(negedge clk);
      if (sd_rd_val_en && rst_n) begin
         check("val_en0", val_en0, exp_owner == 0);
         check("val_en1", val_en1, exp_owner == 1);
         check("val_data0", val_data0, (exp_owner == 0) ? sd_rd_val_data : 16'h0);
         check("val_data1", val_data1, (exp_owner == 1) ? sd_rd_val_data : 16'h0);
      end
   end

   // Issue requests and check grant order, start addresses and done/err against the model.
   task automatic run_reqs(input bit r0, input bit r1, input logic [31:0] a0,
                           input logic [31:0] a1, input logic [15:0] n0,
                           input logic [15:0] n1, output int first_done);
      int          order[$];
      logic [31:0] exp_addr[$];
      int          first, waited, budget;
      logic [15:0] nf;
      first_done = -1;
      first = (r0 && r1) ? ((last_m == 1'b0) ? 1 : 0) : (r1 ? 1 : 0);
      order.push_back(first);
      if (r0 && r1) order.push_back(1 - first);
      foreach (order[j]) begin
         logic [31:0] base;
         logic [15:0] n;
         base = order[j] ? a1 : a0;
         n    = order[j] ? n1 : n0;
         for (int k = 0; k < int'(n); k++) exp_addr.push_back(base + 32'(k));
      end
      nf     = first ? n1 : n0;
      budget = (int'(n0) + int'(n1) + 2) * (busy_len + 30);
      st_addr_q.delete();
      st_cyc_q.delete();
      req0_addr = a0; req0_num = n0; req1_addr = a1; req1_num = n1;
      req0 = r0; req1 = r1;
      exp_owner = first;
      waited = 0;
      if (nf != 16'd0) begin
         @(negedge clk); waited++;
         check("gnt_lat", {30'd0, gnt1, gnt0}, first ? 32'd2 : 32'd1);
         @(negedge clk); waited++;
         check("start_lat", rd_start_en, 1'b1);
      end
      while (order.size() > 0 && waited < budget) begin
         @(negedge clk); waited++;
         if (done0 || done1) begin
            if (first_done < 0) first_done = waited;
            check("done_port", done1, order[0] == 1);
            check("done_both", done0 & done1, 1'b0);
            check("done_err", err0 | err1, 1'b0);
            check("gnt_in_finish", done1 ? gnt1 : gnt0, 1'b1);
            if (done0) req0 = 1'b0;
            if (done1) req1 = 1'b0;
            last_m = done1;
            void'(order.pop_front());
            exp_owner = (order.size() > 0) ? order[0] : -1;
         end
      end
      check("burst_budget", order.size(), 0);
      req0 = 1'b0; req1 = 1'b0;
      exp_owner = -1;
      @(negedge clk);
      check("gnt_drop", {gnt0, gnt1}, 2'b00);
      check("start_count", st_addr_q.size(), exp_addr.size());
      foreach (exp_addr[i]) begin
         if (i < st_addr_q.size()) check("start_addr", st_addr_q[i], exp_addr[i]);
      end
   endtask

   // SD never answers: three starts 22 cycles apart at one address, then done0+err0.
   task automatic run_timeout(input logic [31:0] a);
      int waited;
      bit seen;
      sd_respond = 1'b0;
      st_addr_q.delete();
      st_cyc_q.delete();
      req0_addr = a; req0_num = 16'd2; req0 = 1'b1;
      exp_owner = 0;
      waited = 0; seen = 1'b0;
      while (!seen && waited < 300) begin
         @(negedge clk); waited++;
         if (done0 || done1) begin
            seen = 1'b1;
            check("to_done0", done0, 1'b1);
            check("to_err0", err0, 1'b1);
            check("to_err1", err1, 1'b0);
            if (st_cyc_q.size() > 0) check("to_done_lat", cyc - st_cyc_q[st_cyc_q.size()-1], 21);
         end
      end
      check("to_seen", seen, 1'b1);
      req0 = 1'b0;
      check("to_starts", st_addr_q.size(), 3);
      foreach (st_addr_q[i]) check("to_addr", st_addr_q[i], a);
      for (int i = 1; i < st_cyc_q.size(); i++) check("to_spacing", st_cyc_q[i] - st_cyc_q[i-1], 22);
      last_m = 1'b0;
      sd_respond = 1'b1;
      exp_owner = -1;
      @(negedge clk);
   endtask

   // Reset during the second sector's busy period, then a fresh burst.
   task automatic run_reset_mid();
      int waited;
      int fd;
      busy_len = 10;
      st_addr_q.delete();
      st_cyc_q.delete();
      req0_addr = 32'h0000_1000; req0_num = 16'd3; req0 = 1'b1;
      exp_owner = 0;
      waited = 0;
      while (st_addr_q.size() < 2 && waited < 200) begin @(negedge clk); waited++; end
      check("rm_second_start", st_addr_q.size(), 2);
      waited = 0;
      while (!rd_busy && waited < 20) begin @(negedge clk); waited++; end
      repeat (4) @(negedge clk);
      rst_n = 1'b0; req0 = 1'b0; exp_owner = -1;
      #1;
      check("rm_outs", {23'd0, gnt0, gnt1, done0, done1, err0, err1, rd_start_en, val_en0, val_en1},
            32'd0);
      check("rm_addr", rd_sec_addr, 32'd0);
      check("rm_data", {val_data0, val_data1}, 32'd0);
      last_m = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_reqs(1'b1, 1'b0, 32'h0000_2222, 32'd0, 16'd2, 16'd0, fd);
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int fd;
      rst_n = 1'b0;
      req0 = 1'b0; req1 = 1'b0;
      req0_addr = '0; req1_addr = '0; req0_num = '0; req1_num = '0;
      repeat (3) @(negedge clk);
      check("rst_outs", {25'd0, gnt0, gnt1, done0, done1, err0, err1, rd_start_en}, 32'd0);
      check("rst_addr", rd_sec_addr, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single burst with 100-cycle busy per sector
      busy_len = 100;
      run_reqs(1'b1, 1'b0, 32'd16448, 32'd0, 16'd3, 16'd0, fd);

      // Contention: port 0 first, then port 1
      busy_len = 8;
      run_reqs(1'b1, 1'b1, 32'h0000_0100, 32'h0000_0200, 16'd2, 16'd2, fd);
      // Port 0 alone, so a following tie goes to port 1
      run_reqs(1'b1, 1'b0, 32'h0000_0300, 32'd0, 16'd1, 16'd0, fd);
      run_reqs(1'b1, 1'b1, 32'h0000_0400, 32'h0000_0500, 16'd2, 16'd2, fd);

      // Zero-length burst on port 1
      run_reqs(1'b0, 1'b1, 32'd0, 32'h0000_0600, 16'd0, 16'd0, fd);
      check("zero_done_lat", fd, 1);

      // Stray data while no grant
      sd_stray = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("stray_en", {val_en0, val_en1}, 2'b00);
      end
      sd_stray = 1'b0;
      @(negedge clk);

      run_timeout(32'h0000_0ABC);

      // Address wrap
      run_reqs(1'b1, 1'b0, 32'hFFFF_FFFF, 32'd0, 16'd2, 16'd0, fd);

      run_reset_mid();

      // Randomised bursts
      for (int t = 0; t < 8; t++) begin
         int r;
         r = $urandom_range(1, 3);
         busy_len = $urandom_range(3, 12);
         run_reqs(r[0], r[1], $urandom, $urandom, 16'($urandom_range(0, 3)),
                  16'($urandom_range(0, 3)), fd);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
